mem_arb: RTL and testbench

Two-port memory arbiter and access sequencer for the Simple CPU v1. It shares the single memory bus between the CPU port and an external port (loader/debug DMA). It also sequences each access through a fixed number of memory wait cycles and returns read data with a completion pulse. It sits between the CPU memory control path and the memory array, and owns every memory enable, address, read/write and write-data signal.

---
 rtl/mem_arb.sv | 171 +++++++++++++++++
 tb/tb_mem_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-port memory arbiter and access sequencer for the Simple CPU v1.
// Shares one memory bus between the CPU port and an external (loader/debug DMA)
// port, holds mem_en for WAIT_CYC cycles per access and returns read data with
// a one-cycle ack pulse.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous requests
//                  undefined -> fixed priority, the CPU always wins a tie
//
// WAIT_CYC must be within 1..15 (the wait counter is 4 bits wide).
module mem_arb #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_adrs,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  // external port
  input  logic          ext_req,
  input  logic          ext_rw,
  input  logic [AW-1:0] ext_adrs,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter preload: the first ACCESS cycle counts as one of the WAIT_CYC.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       win_ext;   // 1 = external port owns the current access
  logic       any_req;
  logic       pick_ext;  // arbitration result, only meaningful in IDLE
  logic       last_cnt;  // final cycle of the ACCESS phase

  assign any_req  = cpu_req | ext_req;
  assign last_cnt = (state == ACCESS) && (cnt == 4'd0);

`ifdef MEM_ARB_RR_EN
  // 1 = the external port received the most recent grant.
  logic last_ext;

  // Round-robin choice: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    pick_ext = 1'b0;
    if (ext_req && (!cpu_req || !last_ext))
      pick_ext = 1'b1;
  end

  // Pointer tracks the last granted port; reset favours the CPU on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_ext <= 1'b1;
    else if (state == IDLE && any_req)
      last_ext <= pick_ext;
  end
`else
  // Fixed priority: the external port only wins when the CPU is not requesting.
  always_comb begin
    pick_ext = 1'b0;
    if (ext_req && !cpu_req)
      pick_ext = 1'b1;
  end
`endif

  // Access sequencer: IDLE decision, timed ACCESS window, one-cycle DONE ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      win_ext   <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_adrs  <= '0;
      mem_wdata <= '0;
      cpu_gnt   <= 1'b0;
      ext_gnt   <= 1'b0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          ext_ack <= 1'b0;
          if (any_req) begin
            win_ext   <= pick_ext;
            mem_rw    <= pick_ext ? ext_rw    : cpu_rw;
            mem_adrs  <= pick_ext ? ext_adrs  : cpu_adrs;
            mem_wdata <= pick_ext ? ext_wdata : cpu_wdata;
            cnt       <= CNT_INIT;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            cpu_gnt   <= !pick_ext;
            ext_gnt   <= pick_ext;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          // The grant is a pulse covering only the first ACCESS cycle.
          cpu_gnt <= 1'b0;
          ext_gnt <= 1'b0;
          if (cnt == 4'd0) begin
            mem_en  <= 1'b0;
            cpu_ack <= !win_ext;
            ext_ack <= win_ext;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          // One IDLE cycle always follows, so requesters can drop req after ack.
          cpu_ack <= 1'b0;
          ext_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          mem_en  <= 1'b0;
          cpu_gnt <= 1'b0;
          ext_gnt <= 1'b0;
          cpu_ack <= 1'b0;
          ext_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Read data capture on the last mem_en cycle; writes leave rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else if (last_cnt && !mem_rw) begin
      if (win_ext)
        ext_rdata <= mem_rdata;
      else
        cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: stimulus pushes expected grants/accesses into
// queues, a negedge monitor pops and compares whenever the DUT grants, strobes
// memory or acks. A second instance with WAIT_CYC=1 covers back-to-back spacing.
module tb_mem_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       cpu_req, cpu_rw, cpu_gnt, cpu_ack;
  logic [7:0] cpu_adrs, cpu_wdata, cpu_rdata;
  logic       ext_req, ext_rw, ext_gnt, ext_ack;
  logic [7:0] ext_adrs, ext_wdata, ext_rdata;
  logic       mem_en, mem_rw, busy;
  logic [7:0] mem_adrs, mem_wdata, mem_rdata;

  logic       cpu1_req, cpu1_gnt, cpu1_ack, ext1_gnt, ext1_ack;
  logic [7:0] cpu1_rdata, ext1_rdata;
  logic       mem1_en, mem1_rw, busy1;
  logic [7:0] mem1_adrs, mem1_wdata;
  logic [7:0] mem1_rdata;
  assign mem1_rdata = 8'h77;

  mem_arb #(.AW(8), .DW(8), .WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_rw(ext_rw), .ext_adrs(ext_adrs), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arb #(.AW(8), .DW(8), .WAIT_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu1_req), .cpu_rw(1'b0), .cpu_adrs(8'h55), .cpu_wdata(8'h00),
    .cpu_gnt(cpu1_gnt), .cpu_ack(cpu1_ack), .cpu_rdata(cpu1_rdata),
    .ext_req(1'b0), .ext_rw(1'b0), .ext_adrs(8'h00), .ext_wdata(8'h00),
    .ext_gnt(ext1_gnt), .ext_ack(ext1_ack), .ext_rdata(ext1_rdata),
    .mem_en(mem1_en), .mem_rw(mem1_rw), .mem_adrs(mem1_adrs), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata), .busy(busy1)
  );

  // Memory model: reads return the array only while mem_en is high.
  logic [7:0] tb_mem [256];
  assign mem_rdata = mem_en ? tb_mem[mem_adrs] : 8'hEE;
  always @(posedge clk)
    if (mem_en && mem_rw) tb_mem[mem_adrs] <= mem_wdata;

  typedef struct {
    bit         ext;
    bit         rw;
    logic [7:0] adrs;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } acc_t;

  acc_t sb_acc[$];
  bit   sb_gnt[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gcyc     = 0;
  int en_cnt   = 0;
  logic [7:0] cpu_rd_m = 8'h00;
  logic [7:0] ext_rd_m = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every grant, memory strobe and ack against the queues.
  acc_t a_m;
  bit   e_m;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_gnt || ext_gnt) begin
        if (sb_gnt.size() == 0) chk("unexpected_gnt", {cpu_gnt, ext_gnt}, 0);
        else begin
          e_m = sb_gnt.pop_front();
          chk("gnt_port", {cpu_gnt, ext_gnt}, e_m ? 2'b01 : 2'b10);
          chk("gnt_mem_en", mem_en, 1);
          chk("gnt_busy", busy, 1);
        end
        gcyc   = cyc;
        en_cnt = 0;
      end
      if (mem_en) begin
        en_cnt++;
        if (sb_acc.size() == 0) chk("unexpected_mem_en", mem_en, 0);
        else begin
          chk("mem_rw", mem_rw, sb_acc[0].rw);
          chk("mem_adrs", mem_adrs, sb_acc[0].adrs);
          if (sb_acc[0].rw) chk("mem_wdata", mem_wdata, sb_acc[0].wdata);
        end
      end
      if (cpu_ack || ext_ack) begin
        if (sb_acc.size() == 0) chk("unexpected_ack", {cpu_ack, ext_ack}, 0);
        else begin
          a_m = sb_acc.pop_front();
          chk("ack_port", {cpu_ack, ext_ack}, a_m.ext ? 2'b01 : 2'b10);
          chk("ack_latency", cyc - gcyc, 2);
          chk("mem_en_cycles", en_cnt, 2);
          chk("ack_mem_en_low", mem_en, 0);
          if (!a_m.rw) begin
            if (a_m.ext) ext_rd_m = a_m.rdata;
            else         cpu_rd_m = a_m.rdata;
          end
          chk("cpu_rdata", cpu_rdata, cpu_rd_m);
          chk("ext_rdata", ext_rdata, ext_rd_m);
        end
      end
    end
  end

  task automatic push(input bit ext, input bit rw, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] r);
    acc_t t;
    t.ext = ext; t.rw = rw; t.adrs = a; t.wdata = d; t.rdata = r;
    sb_gnt.push_back(ext);
    sb_acc.push_back(t);
  endtask

  // Waits (bounded) for n acks, then drops both requests and steps into IDLE.
  task automatic wait_acks(input int n, input string nm, output int polls);
    int seen = 0;
    polls = 0;
    for (int i = 0; i < 60 && seen < n; i++) begin
      @(posedge clk); #1;
      polls++;
      if (cpu_ack || ext_ack) seen++;
    end
    chk({nm, "_acks"}, seen, n);
    cpu_req = 1'b0;
    ext_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_cpu_gnt(input string nm);
    int i;
    for (i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (cpu_gnt) break;
    end
    chk({nm, "_gnt_seen"}, (i < 10), 1);
  endtask

  int polls;
  int g, g1, en1, a1;

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i);
    tb_mem[8'h10] = 8'hA5;
    rst_n = 1'b0;
    cpu_req = 0; cpu_rw = 0; cpu_adrs = 0; cpu_wdata = 0;
    ext_req = 0; ext_rw = 0; ext_adrs = 0; ext_wdata = 0;
    cpu1_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_bus", {mem_rw, mem_adrs, mem_wdata}, 0);
    chk("rst_gnt_ack", {cpu_gnt, ext_gnt, cpu_ack, ext_ack}, 0);
    chk("rst_rdata", {cpu_rdata, ext_rdata}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single CPU read of A5 from 0x10
    push(0, 0, 8'h10, 8'h00, 8'hA5);
    cpu_req = 1; cpu_rw = 0; cpu_adrs = 8'h10;
    wait_acks(1, "cpu_read", polls);
    chk("cpu_read_latency", polls, 3);
    chk("cpu_read_ext_rdata", ext_rdata, 8'h00);

    // EXT write of 3C to 0x20
    push(1, 1, 8'h20, 8'h3C, 8'h00);
    ext_req = 1; ext_rw = 1; ext_adrs = 8'h20; ext_wdata = 8'h3C;
    wait_acks(1, "ext_write", polls);
    chk("ext_write_latency", polls, 3);
    chk("ext_write_rdata", ext_rdata, 8'h00);

    // EXT read back of 0x20
    push(1, 0, 8'h20, 8'h00, 8'h3C);
    ext_rw = 0; ext_req = 1;
    wait_acks(1, "ext_read", polls);

    // simultaneous requests held for 4 accesses
`ifdef MEM_ARB_RR_EN
    push(0, 0, 8'h10, 8'h00, 8'hA5);
    push(1, 0, 8'h20, 8'h00, 8'h3C);
    push(0, 0, 8'h10, 8'h00, 8'hA5);
    push(1, 0, 8'h20, 8'h00, 8'h3C);
`else
    for (int i = 0; i < 4; i++) push(0, 0, 8'h10, 8'h00, 8'hA5);
`endif
    cpu_req = 1; cpu_rw = 0; cpu_adrs = 8'h10;
    ext_req = 1; ext_rw = 0; ext_adrs = 8'h20;
    wait_acks(4, "tie4", polls);

    // request dropped right after grant: completes once, no second grant
    push(0, 0, 8'h30, 8'h00, 8'h30);
    cpu_req = 1; cpu_adrs = 8'h30;
    wait_cpu_gnt("drop");
    cpu_req = 0;
    wait_acks(1, "drop", polls);
    repeat (6) @(posedge clk);
    #1;
    chk("drop_no_regrant", sb_gnt.size(), 0);

    // reset asserted mid-ACCESS
    push(0, 0, 8'h40, 8'h00, 8'h40);
    cpu_req = 1; cpu_adrs = 8'h40;
    wait_cpu_gnt("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_en", mem_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt", cpu_gnt, 0);
    cpu_req = 0;
    sb_acc.delete();
    sb_gnt.delete();
    cpu_rd_m = 8'h00;
    ext_rd_m = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_ack", {cpu_ack, ext_ack}, 0);
    chk("rst_mid_rdata", {cpu_rdata, ext_rdata}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // first tie after reset goes to the CPU
    push(0, 0, 8'h10, 8'h00, 8'hA5);
    cpu_req = 1; cpu_adrs = 8'h10;
    ext_req = 1; ext_adrs = 8'h20;
    wait_acks(1, "post_rst_tie", polls);
    chk("post_rst_tie_latency", polls, 3);

    // WAIT_CYC=1 back-to-back CPU reads on the second instance
    g = 0; g1 = 0; en1 = 0; a1 = 0;
    cpu1_req = 1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (cpu1_gnt) begin
        if (g == 1) chk("wc1_spacing", cyc - g1, 3);
        g++;
        g1 = cyc;
        if (g == 2) cpu1_req = 0;
      end
      if (mem1_en) en1++;
      if (cpu1_ack) a1++;
    end
    chk("wc1_grants", g, 2);
    chk("wc1_mem_en_cycles", en1, 2);
    chk("wc1_acks", a1, 2);
    chk("wc1_rdata", cpu1_rdata, 8'h77);
    chk("wc1_busy_end", busy1, 0);

    chk("sb_drain", sb_acc.size() + sb_gnt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
